// File: rtl/input_pkg.sv
// Shared constants for the KEY/SW input conditioner: status word layout,
// ack_mask bit indices and default debounce length.
package input_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned N_KEY_DEF           = 2;
  localparam int unsigned N_SW_DEF            = 10;

  localparam int unsigned STATUS_W       = 16;
  localparam int unsigned ST_SW_LSB      = 0;
  localparam int unsigned ST_KEY_LVL_LSB = 10;
  localparam int unsigned ST_KEY_EVT_LSB = 12;
  localparam int unsigned ST_SW_CHG      = 14;

  localparam int unsigned ACK_MASK_W  = 3;
  localparam int unsigned ACK_KEY_LSB = 0;
  localparam int unsigned ACK_SW_CHG  = 2;

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-FF synchroniser followed by a counter debounce.
// flip_c is high in the cycle whose closing edge changes the stable value.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic flip_c
);

  localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             differ_c;

  assign differ_c = (sync2 != stable);
  assign flip_c   = differ_c && (cnt == CNT_MAX);

  // Any cycle of agreement restarts the count, so short bounces are dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      stable <= RESET_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!differ_c) begin
        cnt <= '0;
      end else if (flip_c) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the board KEY/SW inputs, detects key presses, keeps sticky event
// flags cleared by ack/ack_mask, and packs everything into a status word.
module input_conditioner
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned N_KEY           = N_KEY_DEF,
  parameter int unsigned N_SW            = N_SW_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_KEY-1:0]      key_raw,
  input  logic [N_SW-1:0]       sw_raw,
  output logic [N_KEY-1:0]      key_level,
  output logic [N_KEY-1:0]      key_press,
  output logic [N_SW-1:0]       sw_level,
  output logic [STATUS_W-1:0]   status,
  input  logic                  ack,
  input  logic [ACK_MASK_W-1:0] ack_mask
);

  logic [N_KEY-1:0] key_stable;
  logic [N_KEY-1:0] key_flip_c;
  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_flip_c;
  logic [N_KEY-1:0] key_event;
  logic             sw_changed;
  logic [N_KEY-1:0] key_set_c;
  logic [N_KEY-1:0] key_clr_c;
  logic             sw_clr_c;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
    ) u_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (key_raw[i]),
      .stable  (key_stable[i]),
      .flip_c  (key_flip_c[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (sw_raw[i]),
      .stable  (sw_stable[i]),
      .flip_c  (sw_flip_c[i])
    );
  end

  // A press is a flip while the key is currently released (stable high).
  assign key_set_c = key_flip_c & key_stable;
  assign key_clr_c = {N_KEY{ack}} & ack_mask[ACK_KEY_LSB +: N_KEY];
  assign sw_clr_c  = ack & ack_mask[ACK_SW_CHG];

  // Set takes priority over a coincident clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_press  <= '0;
      key_event  <= '0;
      sw_changed <= 1'b0;
    end else begin
      key_press  <= key_set_c;
      key_event  <= key_set_c | (key_event & ~key_clr_c);
      sw_changed <= (|sw_flip_c) | (sw_changed & ~sw_clr_c);
    end
  end

  assign key_level = ~key_stable;
  assign sw_level  = sw_stable;

  always_comb begin
    status                             = '0;
    status[ST_SW_LSB      +: N_SW]     = sw_stable;
    status[ST_KEY_LVL_LSB +: N_KEY]    = ~key_stable;
    status[ST_KEY_EVT_LSB +: N_KEY]    = key_event;
    status[ST_SW_CHG]                  = sw_changed;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4; stimulus
// queues expected outputs, a negedge monitor pops and compares them.
module tb_input_conditioner;

  logic        clock;
  logic        reset_n;
  logic [1:0]  key_raw;
  logic [9:0]  sw_raw;
  logic [1:0]  key_level;
  logic [1:0]  key_press;
  logic [9:0]  sw_level;
  logic [15:0] status;
  logic        ack;
  logic [2:0]  ack_mask;

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .N_KEY           (2),
    .N_SW            (10)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_raw   (key_raw),
    .sw_raw    (sw_raw),
    .key_level (key_level),
    .key_press (key_press),
    .sw_level  (sw_level),
    .status    (status),
    .ack       (ack),
    .ack_mask  (ack_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  string       q_name[$];
  logic [29:0] q_exp[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [29:0] mon_exp;
  logic [29:0] mon_act;
  string       mon_name;

  // Expected vector: {key_press, key_level, sw_level, status}
  task automatic expect_now(input string nm, input logic [15:0] st, input logic [1:0] kp);
    logic [29:0] v;
    v = {kp, st[11:10], st[9:0], st};
    q_name.push_back(nm);
    q_exp.push_back(v);
  endtask

  task automatic run(input string nm, input int n, input logic [15:0] st, input logic [1:0] kp);
    repeat (n) begin
      @(posedge clock);
      #1;
      expect_now(nm, st, kp);
    end
  endtask

  task automatic set_ack(input logic a, input logic [2:0] m);
    ack      = a;
    ack_mask = m;
  endtask

  always @(negedge clock) begin
    while (q_exp.size() > 0) begin
      mon_exp  = q_exp.pop_front();
      mon_name = q_name.pop_front();
      mon_act  = {key_press, key_level, sw_level, status};
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got press=%b level=%b sw=%h status=%h, want press=%b level=%b sw=%h status=%h",
                 mon_name, mon_act[29:28], mon_act[27:26], mon_act[25:16], mon_act[15:0],
                 mon_exp[29:28], mon_exp[27:26], mon_exp[25:16], mon_exp[15:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    key_raw  = 2'b11;
    sw_raw   = '0;
    ack      = 1'b0;
    ack_mask = '0;

    // 1. reset
    run("reset", 3, 16'h0000, 2'b00);
    reset_n = 1'b1;
    run("idle", 4, 16'h0000, 2'b00);

    // 2. clean press and release of key 0
    key_raw[0] = 1'b0;
    run("press0_wait", 5, 16'h0000, 2'b00);
    run("press0_edge", 1, 16'h1400, 2'b01);
    run("press0_hold", 3, 16'h1400, 2'b00);
    key_raw[0] = 1'b1;
    run("rel0_wait", 5, 16'h1400, 2'b00);
    run("rel0_edge", 1, 16'h1000, 2'b00);
    run("rel0_hold", 2, 16'h1000, 2'b00);

    // 3. bouncing key 1, then a clean hold
    for (int b = 0; b < 5; b++) begin
      key_raw[1] = 1'b0;
      run("bounce_lo", 2, 16'h1000, 2'b00);
      key_raw[1] = 1'b1;
      run("bounce_hi", 2, 16'h1000, 2'b00);
    end
    key_raw[1] = 1'b0;
    run("press1_wait", 5, 16'h1000, 2'b00);
    run("press1_edge", 1, 16'h3800, 2'b10);
    run("press1_hold", 2, 16'h3800, 2'b00);
    key_raw[1] = 1'b1;
    run("rel1_wait", 5, 16'h3800, 2'b00);
    run("rel1_edge", 1, 16'h3000, 2'b00);
    set_ack(1'b1, 3'b011);
    run("ack_keys", 1, 16'h0000, 2'b00);
    set_ack(1'b0, 3'b000);

    // 4. switch change and masked acks
    sw_raw[3] = 1'b1;
    run("sw3_wait", 5, 16'h0000, 2'b00);
    run("sw3_edge", 1, 16'h4008, 2'b00);
    run("sw3_hold", 2, 16'h4008, 2'b00);
    set_ack(1'b1, 3'b100);
    run("ack_sw", 1, 16'h0008, 2'b00);
    set_ack(1'b0, 3'b000);
    run("ack_sw_after", 1, 16'h0008, 2'b00);
    sw_raw[3] = 1'b0;
    run("sw3_off_wait", 5, 16'h0008, 2'b00);
    run("sw3_off_edge", 1, 16'h4000, 2'b00);
    set_ack(1'b1, 3'b011);
    run("ack_keys_only", 1, 16'h4000, 2'b00);
    set_ack(1'b1, 3'b000);
    run("ack_mask_zero", 1, 16'h4000, 2'b00);
    set_ack(1'b1, 3'b100);
    run("ack_sw_again", 1, 16'h0000, 2'b00);
    set_ack(1'b0, 3'b000);

    // 5. set and ack on the same edge
    key_raw[0] = 1'b0;
    run("coll_wait", 5, 16'h0000, 2'b00);
    set_ack(1'b1, 3'b001);
    run("coll_edge", 1, 16'h1400, 2'b01);
    set_ack(1'b0, 3'b000);
    run("coll_after", 1, 16'h1400, 2'b00);
    set_ack(1'b1, 3'b001);
    run("coll_reack", 1, 16'h0400, 2'b00);
    set_ack(1'b0, 3'b000);
    key_raw[0] = 1'b1;
    run("coll_rel_wait", 5, 16'h0400, 2'b00);
    run("coll_rel_edge", 1, 16'h0000, 2'b00);

    // 6. reset while a switch count is in progress
    sw_raw[0] = 1'b1;
    run("rmid_pre", 3, 16'h0000, 2'b00);
    reset_n = 1'b0;
    run("rmid_rst", 2, 16'h0000, 2'b00);
    reset_n = 1'b1;
    run("rmid_wait", 5, 16'h0000, 2'b00);
    run("rmid_edge", 1, 16'h4001, 2'b00);
    run("rmid_hold", 2, 16'h4001, 2'b00);

    @(negedge clock);
    #1;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
